// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the MEM stage: one access at a time with a fixed
// number of wait states, stalling the pipeline until the access completes.
module data_mem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        err
);

    localparam int DATA_W = 32;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_rd;
    logic              lat_wr;
    logic              accept;
    logic              enter_resp;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_rd;
    logic              acc_wr;
    logic              acc_bad;

    logic [DATA_W-1:0] ram [DEPTH];

    // Full 32-bit range check so out-of-range addresses never alias into the RAM.
    function automatic logic is_illegal(input logic [31:0] a, input logic rd, input logic wr);
        return (a >= 32'(DEPTH)) || (rd && wr);
    endfunction

    // With zero wait states the access completes on the accepting edge, so the
    // live inputs stand in for the not-yet-latched request.
    always_comb begin
        acc_addr  = (state == IDLE) ? addr      : lat_addr;
        acc_wdata = (state == IDLE) ? wdata     : lat_wdata;
        acc_rd    = (state == IDLE) ? mem_read  : lat_rd;
        acc_wr    = (state == IDLE) ? mem_write : lat_wr;
        acc_bad   = is_illegal(acc_addr, acc_rd, acc_wr);
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stall      = 1'b0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    stall   = 1'b1;
                    accept  = 1'b1;
                    cnt_nxt = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                stall   = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            stall      = 1'b0;
            accept     = 1'b0;
            enter_resp = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= enter_resp;
            err   <= enter_resp && acc_bad;
            if (accept) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_rd    <= mem_read;
                lat_wr    <= mem_write;
            end
            if (enter_resp && acc_rd) begin
                rdata <= acc_bad ? '0 : ram[acc_addr[AW-1:0]];
            end
        end
    end

    // RAM has no reset; contents persist across reset.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_wr && !acc_bad) begin
            ram[acc_addr[AW-1:0]] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed corner cases plus randomized accesses
// checked against an array model of the RAM and the expected latency.
module tb_data_mem_ctrl;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic        err;

    logic        d0_read = 1'b0;
    logic        d0_write = 1'b0;
    logic [31:0] d0_addr = '0;
    logic [31:0] d0_wdata = '0;
    logic [31:0] d0_rdata;
    logic        d0_ready;
    logic        d0_stall;
    logic        d0_err;

    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_rdata = '0;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .stall(stall), .err(err)
    );

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(d0_read), .mem_write(d0_write),
        .addr(d0_addr), .wdata(d0_wdata), .rdata(d0_rdata), .ready(d0_ready),
        .stall(d0_stall), .err(d0_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access on the W=2 instance; scr scrambles inputs while waiting.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit scr);
        logic bad;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        #1 chk("stall_req", 32'(stall), 32'd1);
        @(posedge clk);
        bad = (a >= 32'(DEPTH)) || (rd && wr);
        if (rd) exp_rdata = bad ? 32'd0 : mdl[a % DEPTH];
        if (wr && !bad) mdl[a % DEPTH] = d;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k <= W) begin
                chk("stall_wait", 32'(stall), 32'd1);
                chk("ready_early", 32'(ready), 32'd0);
            end else begin
                chk("ready", 32'(ready), 32'd1);
                chk("err", 32'(err), 32'(bad));
                chk("stall_resp", 32'(stall), 32'd0);
                chk("rdata", rdata, exp_rdata);
            end
            if (scr && k <= W) begin
                addr = $urandom; wdata = $urandom;
                mem_read = 1'($urandom); mem_write = 1'($urandom);
            end else begin
                mem_read = 1'b0; mem_write = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          op;

        mem_read = 1'b1; d0_write = 1'b1;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_stall0", 32'(d0_stall), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        mem_read = 1'b0; d0_write = 1'b0;
        @(posedge clk); #2 rst = 1'b1;

        // Zero-wait-state instance: preload then back-to-back reads
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            d0_write = 1'b1; d0_addr = i; d0_wdata = 32'h11 * i;
            #1 chk("w0_stall_req", 32'(d0_stall), 32'd1);
            @(negedge clk);
            chk("w0_wr_ready", 32'(d0_ready), 32'd1);
            chk("w0_wr_err", 32'(d0_err), 32'd0);
            d0_write = 1'b0;
        end
        @(negedge clk);
        d0_read = 1'b1; d0_addr = 32'd1;
        #1 chk("w0_stall_acc1", 32'(d0_stall), 32'd1);
        @(negedge clk);
        chk("w0_ready1", 32'(d0_ready), 32'd1);
        chk("w0_rdata1", d0_rdata, 32'h11);
        chk("w0_stall_resp1", 32'(d0_stall), 32'd0);
        d0_addr = 32'd2;
        @(negedge clk);
        chk("w0_ready_gap", 32'(d0_ready), 32'd0);
        chk("w0_stall_acc2", 32'(d0_stall), 32'd1);
        @(negedge clk);
        chk("w0_ready2", 32'(d0_ready), 32'd1);
        chk("w0_rdata2", d0_rdata, 32'h22);
        chk("w0_stall_resp2", 32'(d0_stall), 32'd0);
        d0_read = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            access(1'b0, 1'b1, 32'(i), (i == 7) ? 32'hA5A5_0007 : $urandom, 1'b0);

        access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
        access(1'b1, 1'b0, 32'd256, 32'd0, 1'b0);
        access(1'b0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 1'b0);
        access(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        access(1'b1, 1'b1, 32'd3, 32'h0BAD_0BAD, 1'b0);
        access(1'b1, 1'b0, 32'd3, 32'd0, 1'b0);
        access(1'b0, 1'b1, 32'd9, 32'h9999_0009, 1'b1);
        access(1'b1, 1'b0, 32'd9, 32'd0, 1'b1);

        // Reset during WAIT aborts the write to address 7
        @(negedge clk);
        mem_write = 1'b1; addr = 32'd7; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_stall", 32'(stall), 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        mem_write = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        access(1'b1, 1'b0, 32'd7, 32'd0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            a  = 32'($urandom_range(0, DEPTH - 1));
            case (op)
                0, 1, 2, 3: access(1'b1, 1'b0, a, 32'd0, 1'($urandom));
                4, 5, 6:    access(1'b0, 1'b1, a, $urandom, 1'($urandom));
                7:          access(1'b1, 1'b0, 32'(DEPTH) + 32'($urandom_range(0, 5000)), 32'd0, 1'b1);
                8:          access(1'b0, 1'b1, 32'hFFFF_FF00 | a, $urandom, 1'b1);
                default:    access(1'b1, 1'b1, a, $urandom, 1'b1);
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
